ram_mfa_mfc_memory: RTL and testbench

- Byte-addressed 512-byte synchronous data/instruction memory for the multicycle datapath, directly downstream of the control unit.
- Accepts the control unit's memory request (MFA, RW, DataSize, Address) and data from MDR.
- Performs the read or write after a fixed programmable latency and signals completion with MFC, which the fetch wait state polls.
- Big-endian, with alignment checking.

---
 rtl/ram_mfa_mfc_memory_pkg.sv | 9 +
 rtl/ram_mfa_mfc_memory_if.sv | 14 +
 rtl/ram_mfa_mfc_memory_mem_byte_lane_align.sv | 22 ++
 rtl/ram_mfa_mfc_memory.sv | 76 +++++++
 tb/tb_ram_mfa_mfc_memory.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ram_mfa_mfc_memory_pkg.sv
// ram_mfa_mfc_memory_pkg: shared access-size encodings, memory FSM states and trap vector
package ram_mfa_mfc_memory_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FETCH = 2'b11;
  localparam int TRAP_VECTOR = 448;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/ram_mfa_mfc_memory_if.sv
// ram_mfa_mfc_memory_if: control-unit request / memory completion bus
interface ram_mfa_mfc_memory_if #(parameter int ADDR_WIDTH = 9);
  logic MFA;
  logic RW;
  logic [1:0] DataSize;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic MFC;
  logic addrError;
  logic busy;
  modport master(output MFA, RW, DataSize, Address, DataIn, input DataOut, MFC, addrError, busy);
  modport slave(input MFA, RW, DataSize, Address, DataIn, output DataOut, MFC, addrError, busy);
endinterface

// File: rtl/ram_mfa_mfc_memory_mem_byte_lane_align.sv
// ram_mfa_mfc_memory_mem_byte_lane_align: big-endian lane steering and alignment check within one word
module ram_mfa_mfc_memory_mem_byte_lane_align
  import ram_mfa_mfc_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wbytes,
  output logic [31:0] rdata,
  output logic        misalign
);
  // lane k is byte address base+k and sits in rword[31-8k -: 8]
  always_comb begin
    misalign = (size == SZ_HALF && addr[0]) || ((size == SZ_WORD || size == SZ_FETCH) && addr != 2'b00);
    be = misalign ? 4'b0000 : size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wbytes = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = misalign ? 32'h0 : size == SZ_BYTE ? {24'h0, rword[{~addr, 3'b000} +: 8]} :
            size == SZ_HALF ? {16'h0, rword[{~addr[1], 4'b0000} +: 16]} : rword;
  end
endmodule

// File: rtl/ram_mfa_mfc_memory.sv
// ram_mfa_mfc_memory: byte-addressed big-endian memory with MFA/MFC handshake and fixed latency
module ram_mfa_mfc_memory
  import ram_mfa_mfc_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH = 512,
  parameter int LATENCY = 2,
  parameter INIT_FILE = ""
) (
  input logic Clk,
  input logic reset,
  ram_mfa_mfc_memory_if.slave bus
);
  logic [7:0] mem [DEPTH];
  mem_state_t state;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] r_addr, base;
  logic r_rw;
  logic [1:0] r_size;
  logic [31:0] r_din, rword, wbytes, rdata, dout;
  logic [3:0] be;
  logic misalign, fire, mfc, addr_error, busy;
  assign base = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rword = {mem[base], mem[base + ADDR_WIDTH'(1)], mem[base + ADDR_WIDTH'(2)], mem[base + ADDR_WIDTH'(3)]};
  assign fire = state == BUSY && bus.MFA && cnt == 4'd0;
  ram_mfa_mfc_memory_mem_byte_lane_align u_align (
    .size(r_size), .addr(r_addr[1:0]), .wdata(r_din), .rword(rword),
    .be(be), .wbytes(wbytes), .rdata(rdata), .misalign(misalign)
  );
  always_ff @(posedge Clk)
    if (fire && r_rw && !reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[base + ADDR_WIDTH'(i)] <= wbytes[31-8*i -: 8];
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
      mfc <= 1'b0;
      addr_error <= 1'b0;
      busy <= 1'b0;
      dout <= 32'h0;
    end else begin
      case (state)
        IDLE: if (bus.MFA) begin
          r_addr <= bus.Address;
          r_rw <= bus.RW;
          r_size <= bus.DataSize;
          r_din <= bus.DataIn;
          cnt <= 4'(LATENCY - 1);
          busy <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (!bus.MFA) begin
          busy <= 1'b0;
          state <= IDLE;
        end else if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          mfc <= 1'b1;
          addr_error <= misalign;
          dout <= r_rw ? 32'h0 : rdata;
          state <= DONE;
        end
        default: if (!bus.MFA) begin
          mfc <= 1'b0;
          addr_error <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.DataOut = dout;
  assign bus.MFC = mfc;
  assign bus.addrError = addr_error;
  assign bus.busy = busy;
endmodule

// File: tb/tb_ram_mfa_mfc_memory.sv
// tb_ram_mfa_mfc_memory: three DUTs (LATENCY 1, 2, 5) on shared stimulus, checked against a byte-array model
module tb_ram_mfa_mfc_memory;
  logic clk = 0, reset = 1, mfa = 0, rw = 0;
  logic [1:0] sz = 0;
  logic [8:0] addr = 0;
  logic [31:0] din = 0;
  logic [2:0] mfc_v, ae_v, busy_v;
  logic [31:0] dout_v [3];
  int checks = 0, passed = 0;
  int ed [3];
  logic [31:0] q;
  logic e;
  always #5 clk = ~clk;

  ram_mfa_mfc_memory_if b [3] ();
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign b[g].MFA = mfa;
    assign b[g].RW = rw;
    assign b[g].DataSize = sz;
    assign b[g].Address = addr;
    assign b[g].DataIn = din;
    assign mfc_v[g] = b[g].MFC;
    assign ae_v[g] = b[g].addrError;
    assign busy_v[g] = b[g].busy;
    assign dout_v[g] = b[g].DataOut;
    ram_mfa_mfc_memory #(.LATENCY(g == 0 ? 1 : g == 1 ? 2 : 5)) u_dut (.Clk(clk), .reset(reset), .bus(b[g]));
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask

  // model: a request completes after LAT+1 consecutive edges with MFA high
  int lat [3] = '{1, 2, 5};
  int k [3];
  logic [7:0] mm [3][512];
  logic [8:0] la [3];
  logic lw [3];
  logic [1:0] ls [3];
  logic [31:0] ld [3];
  logic m_mfc [3], m_ae [3], m_busy [3];
  logic [31:0] m_dout [3];
  bit armed = 0;

  task automatic access(input int d);
    int n;
    logic [31:0] v;
    n = ls[d] == 2'd0 ? 1 : ls[d] == 2'd1 ? 2 : 4;
    m_mfc[d] = 1;
    m_ae[d] = (la[d] % n) != 0;
    v = 0;
    if (!m_ae[d]) begin
      for (int i = 0; i < n; i++)
        if (lw[d]) mm[d][la[d] + i] = 8'(ld[d] >> (8 * (n - 1 - i)));
        else v = (v << 8) | {24'h0, mm[d][la[d] + i]};
    end
    m_dout[d] = v;
  endtask

  always @(posedge clk) begin
    armed = 1;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        k[d] = 0; m_mfc[d] = 0; m_ae[d] = 0; m_busy[d] = 0; m_dout[d] = 0;
      end else if (!mfa) begin
        k[d] = 0; m_mfc[d] = 0; m_ae[d] = 0; m_busy[d] = 0;
      end else begin
        k[d]++;
        if (k[d] == 1) begin la[d] = addr; lw[d] = rw; ls[d] = sz; ld[d] = din; end
        m_busy[d] = 1;
        if (k[d] == lat[d] + 1) access(d);
      end
    end
  end

  always @(negedge clk)
    if (armed)
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("cyc_mfc%0d", d), 32'(mfc_v[d]), 32'(m_mfc[d]));
        chk($sformatf("cyc_ae%0d", d), 32'(ae_v[d]), 32'(m_ae[d]));
        chk($sformatf("cyc_busy%0d", d), 32'(busy_v[d]), 32'(m_busy[d]));
        chk($sformatf("cyc_dout%0d", d), dout_v[d], m_dout[d]);
      end

  task automatic go(input logic w, input logic [1:0] s, input logic [8:0] a, input logic [31:0] dd);
    rw = w; sz = s; addr = a; din = dd; mfa = 1;
    ed = '{-1, -1, -1};
    for (int c = 1; c <= 40 && (ed[0] < 0 || ed[1] < 0 || ed[2] < 0); c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) if (ed[d] < 0 && mfc_v[d]) ed[d] = c;
    end
    if (ed[0] < 0 || ed[1] < 0 || ed[2] < 0) chk("mfc_timeout", 32'(mfc_v), 32'h7);
    q = dout_v[1];
    e = ae_v[1];
  endtask

  task automatic req(input logic w, input logic [1:0] s, input logic [8:0] a, input logic [31:0] dd, input int hold);
    go(w, s, a, dd);
    repeat (hold) @(posedge clk);
    #1 mfa = 0;
    @(posedge clk); #1;
    chk("mfc_fall", 32'(mfc_v), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mfc", 32'(mfc_v), 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_dout", dout_v[1], 32'h0);
    reset = 0;
    req(1, 2'b10, 9'd8, 32'hDEADBEEF, 0);
    chk("lat1_edges", 32'(ed[0]), 32'd2);
    chk("lat2_edges", 32'(ed[1]), 32'd3);
    chk("lat5_edges", 32'(ed[2]), 32'd6);
    chk("wr_ae", 32'(e), 32'h0);
    chk("wr_dout", q, 32'h0);
    req(0, 2'b11, 9'd8, 32'h0, 0);
    chk("rd_word8", q, 32'hDEADBEEF);
    req(0, 2'b00, 9'd9, 32'h0, 0);
    chk("rd_byte9", q, 32'h000000AD);
    req(0, 2'b01, 9'd10, 32'h0, 0);
    chk("rd_half10", q, 32'h0000BEEF);
    req(1, 2'b00, 9'd11, 32'h00000012, 0);
    req(0, 2'b10, 9'd8, 32'h0, 0);
    chk("rd_after_byte", q, 32'hDEADBE12);
    req(1, 2'b10, 9'd4, 32'h01020304, 0);
    req(1, 2'b10, 9'd6, 32'h11111111, 0);
    chk("mis_wr_ae", 32'(e), 32'h1);
    chk("mis_wr_dout", q, 32'h0);
    req(0, 2'b10, 9'd4, 32'h0, 0);
    chk("mis_rd4", q, 32'h01020304);
    req(0, 2'b10, 9'd8, 32'h0, 0);
    chk("mis_rd8", q, 32'hDEADBE12);
    req(0, 2'b01, 9'd3, 32'h0, 0);
    chk("mis_half_ae", 32'(e), 32'h1);
    chk("mis_half_dout", q, 32'h0);
    req(1, 2'b10, 9'd16, 32'h55667788, 0);
    rw = 1; sz = 2'b10; addr = 9'd16; din = 32'hCAFEBABE; mfa = 1;
    @(posedge clk); #1 mfa = 0;
    @(posedge clk); #1;
    chk("abort_mfc", 32'(mfc_v), 32'h0);
    chk("abort_busy", 32'(busy_v), 32'h0);
    repeat (6) @(posedge clk);
    #1 chk("abort_no_mfc", 32'(mfc_v), 32'h0);
    req(0, 2'b10, 9'd16, 32'h0, 0);
    chk("abort_rd16", q, 32'h55667788);
    go(0, 2'b10, 9'd8, 32'h0);
    chk("pre_rst_dout", q, 32'hDEADBE12);
    reset = 1;
    @(posedge clk); #1;
    chk("rstd_mfc", 32'(mfc_v), 32'h0);
    chk("rstd_busy", 32'(busy_v), 32'h0);
    chk("rstd_dout", dout_v[1], 32'h0);
    reset = 0; mfa = 0;
    @(posedge clk); #1;
    req(0, 2'b10, 9'd8, 32'h0, 0);
    chk("post_rst_rd8", q, 32'hDEADBE12);
    req(1, 2'b10, 9'd508, 32'h0BADF00D, 10);
    chk("hold_lat1", 32'(ed[0]), 32'd2);
    chk("hold_lat5", 32'(ed[2]), 32'd6);
    req(0, 2'b10, 9'd508, 32'h0, 10);
    chk("top_word", q, 32'h0BADF00D);
    req(0, 2'b00, 9'd511, 32'h0, 0);
    chk("top_byte", q, 32'h0000000D);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
